// File: rtl/as6500_pkg.sv
// Shared definitions for the AS6500 SPI slave emulator: opcode encodings,
// result-buffer base address and the state/mode enumerations.
package as6500_pkg;

  // Full-byte opcodes
  localparam logic [7:0] OP_POR   = 8'h30;
  localparam logic [7:0] OP_INIT  = 8'h18;
  // Opcode prefixes (bits [7:5]); bits [4:0] carry the start address
  localparam logic [2:0] OP_WRCFG = 3'b100;
  localparam logic [2:0] OP_RDCFG = 3'b010;
  localparam logic [2:0] OP_RDRES = 3'b011;

  // First address of the result buffer
  localparam int unsigned RES_BASE = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPCODE = 2'd1,
    ST_DATA   = 2'd2
  } frame_state_e;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'd0,
    MODE_WRCFG = 2'd1,
    MODE_RDCFG = 2'd2,
    MODE_RDRES = 2'd3
  } data_mode_e;

  // Opcodes that are matched on the whole byte rather than on a prefix
  function automatic logic is_fixed_op(input logic [7:0] op);
    return (op == OP_POR) || (op == OP_INIT);
  endfunction

endpackage

// File: rtl/as6500_spi_sync.sv
// Two-flop synchronizers for SSN/SCK/MOSI plus edge strobes. Each strobe is
// high for one cycle, two clocks after the pin change is first captured.
module as6500_spi_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ssn_pin,
  input  logic sck_pin,
  input  logic mosi_pin,
  output logic mosi_s,
  output logic ssn_fall_s,
  output logic ssn_rise_s,
  output logic sck_rise_s,
  output logic sck_fall_s
);

  // [0],[1] form the synchronizer, [2] is the edge-detect delay stage
  logic [2:0] ssn_q;
  logic [2:0] sck_q;
  logic [1:0] mosi_q;

  // Capture the asynchronous pins; SSN resets to its idle-high level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssn_q  <= 3'b111;
      sck_q  <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      ssn_q  <= {ssn_q[1:0], ssn_pin};
      sck_q  <= {sck_q[1:0], sck_pin};
      mosi_q <= {mosi_q[0], mosi_pin};
    end
  end

  assign mosi_s     = mosi_q[1];
  assign ssn_fall_s = ssn_q[2] & ~ssn_q[1];
  assign ssn_rise_s = ~ssn_q[2] & ssn_q[1];
  assign sck_rise_s = ~sck_q[2] & sck_q[1];
  assign sck_fall_s = sck_q[2] & ~sck_q[1];

endmodule

// File: rtl/as6500_spi_emu.sv
// AS6500 TDC SPI slave emulator (mode 1, MSB first). Optional protocol
// checking is built when AS6500_EMU_ERRCHK_EN is defined; otherwise
// o_proto_err is tied low.
module as6500_spi_emu
  import as6500_pkg::*;
#(
  parameter int CFG_REGS  = 17,
  parameter int RES_BYTES = 24
) (
  input  logic                   i_clk_100m,
  input  logic                   i_rst_n,
  input  logic                   i_tdc_spi_ssn,
  input  logic                   i_tdc_spi_clk,
  input  logic                   i_tdc_spi_mosi,
  output logic                   o_tdc_spi_miso,
  output logic                   o_tdc_intn,
  input  logic                   i_res_load,
  input  logic [RES_BYTES*8-1:0] i_res_data,
  output logic                   o_meas_en,
  output logic                   o_cfg_wr,
  output logic [4:0]             o_cfg_addr,
  output logic [7:0]             o_cfg_data,
  output logic                   o_proto_err
);

  logic mosi_s, ssn_fall_s, ssn_rise_s, sck_rise_s, sck_fall_s;

  as6500_spi_sync u_sync (
    .clk        (i_clk_100m),
    .rst_n      (i_rst_n),
    .ssn_pin    (i_tdc_spi_ssn),
    .sck_pin    (i_tdc_spi_clk),
    .mosi_pin   (i_tdc_spi_mosi),
    .mosi_s     (mosi_s),
    .ssn_fall_s (ssn_fall_s),
    .ssn_rise_s (ssn_rise_s),
    .sck_rise_s (sck_rise_s),
    .sck_fall_s (sck_fall_s)
  );

  // Front end: framing, bit assembly and MISO
  frame_state_e state_q;
  logic [2:0]   bit_cnt_q;
  logic [6:0]   shift_q;
  logic [7:0]   byte_q;
  logic         byte_vld_q, is_op_q, end_q, abort_q, miso_q;
  logic [7:0]   tx_byte_s;

  // Back end: register file, result buffer and interrupt
  data_mode_e             mode_q, mode_d;
  logic [4:0]             addr_q, addr_d, cfg_next_s, res_next_s;
  logic                   rd_any_q, rd_any_d, meas_en_q, meas_en_d;
  logic                   intn_q, intn_d, pending_q, pending_d, por_s;
  logic [7:0]             cfg_q [CFG_REGS];
  logic [7:0]             cfg_d [CFG_REGS];
  logic [RES_BYTES*8-1:0] res_q, res_d, pend_q, pend_d;
  logic                   cfg_wr_q, cfg_wr_d;
  logic [4:0]             cfg_addr_q, cfg_addr_d;
  logic [7:0]             cfg_data_q, cfg_data_d;

  // Frame FSM: SSN framing, byte assembly on SCK fall, MISO update on SCK rise
  always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      byte_q     <= 8'h00;
      byte_vld_q <= 1'b0;
      is_op_q    <= 1'b0;
      end_q      <= 1'b0;
      abort_q    <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      end_q      <= 1'b0;
      if (ssn_rise_s) begin
        end_q     <= (state_q != ST_IDLE);
        abort_q   <= (state_q != ST_IDLE) && (bit_cnt_q != 3'd0);
        state_q   <= ST_IDLE;
        bit_cnt_q <= 3'd0;
        miso_q    <= 1'b0;
      end else if (ssn_fall_s) begin
        state_q   <= ST_OPCODE;
        bit_cnt_q <= 3'd0;
        miso_q    <= 1'b0;
      end else if (state_q != ST_IDLE) begin
        if (sck_fall_s) begin
          shift_q   <= {shift_q[5:0], mosi_s};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_q     <= {shift_q, mosi_s};
            byte_vld_q <= 1'b1;
            is_op_q    <= (state_q == ST_OPCODE);
            state_q    <= ST_DATA;
          end
        end else if (sck_rise_s) begin
          // bit_cnt counts falls so far, so it selects the bit for this rise
          miso_q <= (state_q == ST_DATA) ? tx_byte_s[3'd7 - bit_cnt_q] : 1'b0;
        end
      end
    end
  end

  // Byte presented on MISO for the current read address (0 when not reading)
  always_comb begin
    tx_byte_s = 8'h00;
    case (mode_q)
      MODE_RDCFG: begin
        for (int i = 0; i < CFG_REGS; i++) begin
          tx_byte_s = (addr_q == 5'(i)) ? cfg_q[i] : tx_byte_s;
        end
      end
      MODE_RDRES: begin
        for (int i = 0; i < RES_BYTES; i++) begin
          tx_byte_s = (addr_q == 5'(RES_BASE + i)) ? res_q[i*8 +: 8] : tx_byte_s;
        end
      end
      default: tx_byte_s = 8'h00;
    endcase
  end

  // Auto-increment targets with wrap for each address window
  assign cfg_next_s = ({1'b0, addr_q} >= 6'(CFG_REGS - 1)) ? 5'd0 : addr_q + 5'd1;
  assign res_next_s = ({1'b0, addr_q} >= 6'(RES_BASE + RES_BYTES - 1)) ? 5'(RES_BASE)
                                                                       : addr_q + 5'd1;

  // Opcode decode, data-byte actions, frame close-out, result loading and POR
  always_comb begin
    mode_d     = mode_q;
    addr_d     = addr_q;
    rd_any_d   = rd_any_q;
    meas_en_d  = meas_en_q;
    intn_d     = intn_q;
    pending_d  = pending_q;
    cfg_d      = cfg_q;
    res_d      = res_q;
    pend_d     = pend_q;
    cfg_wr_d   = 1'b0;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    por_s      = 1'b0;
    if (end_q) begin
      // Only a read that completed at least one byte, and did not stop mid-byte, acknowledges
      if ((mode_q == MODE_RDRES) && rd_any_q && !abort_q) begin
        intn_d = 1'b1;
      end else begin
        intn_d = intn_q;
      end
      if (pending_q) begin
        res_d  = pend_q;
        intn_d = 1'b0;
      end else begin
        res_d = res_q;
      end
      mode_d    = MODE_NONE;
      rd_any_d  = 1'b0;
      pending_d = 1'b0;
    end else if (byte_vld_q && is_op_q) begin
      if (byte_q == OP_POR) begin
        por_s  = 1'b1;
        mode_d = MODE_NONE;
      end else if (byte_q == OP_INIT) begin
        meas_en_d = 1'b1;
        intn_d    = 1'b1;
        mode_d    = MODE_NONE;
      end else begin
        case (byte_q[7:5])
          OP_WRCFG: mode_d = ({1'b0, byte_q[4:0]} < 6'(CFG_REGS)) ? MODE_WRCFG : MODE_NONE;
          OP_RDCFG: mode_d = MODE_RDCFG;
          OP_RDRES: mode_d = MODE_RDRES;
          default:  mode_d = MODE_NONE;
        endcase
        addr_d = ((byte_q[7:5] == OP_RDRES) && (byte_q[4:0] < 5'(RES_BASE))) ? 5'(RES_BASE)
                                                                             : byte_q[4:0];
      end
    end else if (byte_vld_q) begin
      case (mode_q)
        MODE_WRCFG: begin
          for (int i = 0; i < CFG_REGS; i++) begin
            cfg_d[i] = (addr_q == 5'(i)) ? byte_q : cfg_q[i];
          end
          cfg_wr_d   = 1'b1;
          cfg_addr_d = addr_q;
          cfg_data_d = byte_q;
          addr_d     = cfg_next_s;
        end
        MODE_RDCFG: addr_d = cfg_next_s;
        MODE_RDRES: begin
          addr_d   = res_next_s;
          rd_any_d = 1'b1;
        end
        default: addr_d = addr_q;
      endcase
    end else begin
      mode_d = mode_q;
    end
    // A load arriving during a result read is deferred so the frame stays coherent
    if (i_res_load && meas_en_q) begin
      if ((mode_q == MODE_RDRES) && !end_q) begin
        pending_d = 1'b1;
        pend_d    = i_res_data;
      end else begin
        res_d     = i_res_data;
        intn_d    = 1'b0;
        pending_d = 1'b0;
      end
    end else begin
      pend_d = pend_q;
    end
    if (por_s) begin
      for (int i = 0; i < CFG_REGS; i++) begin
        cfg_d[i] = 8'h00;
      end
      meas_en_d = 1'b0;
      intn_d    = 1'b1;
      pending_d = 1'b0;
    end else begin
      meas_en_d = meas_en_d;
    end
  end

  // Back-end state registers
  always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q     <= MODE_NONE;
      addr_q     <= 5'd0;
      rd_any_q   <= 1'b0;
      meas_en_q  <= 1'b0;
      intn_q     <= 1'b1;
      pending_q  <= 1'b0;
      res_q      <= '0;
      pend_q     <= '0;
      cfg_wr_q   <= 1'b0;
      cfg_addr_q <= 5'd0;
      cfg_data_q <= 8'h00;
      for (int i = 0; i < CFG_REGS; i++) begin
        cfg_q[i] <= 8'h00;
      end
    end else begin
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      rd_any_q   <= rd_any_d;
      meas_en_q  <= meas_en_d;
      intn_q     <= intn_d;
      pending_q  <= pending_d;
      res_q      <= res_d;
      pend_q     <= pend_d;
      cfg_wr_q   <= cfg_wr_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
      cfg_q      <= cfg_d;
    end
  end

`ifdef AS6500_EMU_ERRCHK_EN
  logic err_q, err_d, err_set_s;

  // Classify protocol violations from the registered frame/byte events
  always_comb begin
    err_set_s = 1'b0;
    if (end_q) begin
      err_set_s = abort_q;
    end else if (byte_vld_q && is_op_q && !is_fixed_op(byte_q)) begin
      case (byte_q[7:5])
        OP_WRCFG: err_set_s = !({1'b0, byte_q[4:0]} < 6'(CFG_REGS));
        OP_RDCFG: err_set_s = 1'b0;
        OP_RDRES: err_set_s = !meas_en_q;
        default:  err_set_s = 1'b1;
      endcase
    end else begin
      err_set_s = 1'b0;
    end
    err_d = por_s ? 1'b0 : (err_q | err_set_s);
  end

  // Sticky error flag, cleared only by reset or the POR opcode
  always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_proto_err = err_q;
`else
  assign o_proto_err = 1'b0;
`endif

  assign o_tdc_spi_miso = miso_q;
  assign o_tdc_intn     = intn_q;
  assign o_meas_en      = meas_en_q;
  assign o_cfg_wr       = cfg_wr_q;
  assign o_cfg_addr     = cfg_addr_q;
  assign o_cfg_data     = cfg_data_q;

endmodule

// File: tb/tb_as6500_spi_emu.sv
// Directed bench for as6500_spi_emu: 10 MHz SPI mode-1 frames from a
// 100 MHz system clock, hand-computed expectations.
`timescale 1ns/1ps
module tb_as6500_spi_emu;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ssn = 1'b1;
  logic         sck = 1'b0;
  logic         mosi = 1'b0;
  logic         res_load = 1'b0;
  logic [191:0] res_data = '0;
  logic         miso, intn, meas_en, cfg_wr, proto_err;
  logic [4:0]   cfg_addr;
  logic [7:0]   cfg_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] wr_a[$];
  logic [7:0] wr_d[$];

`ifdef AS6500_EMU_ERRCHK_EN
  localparam logic EXP_ABORT_ERR = 1'b1;
`else
  localparam logic EXP_ABORT_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  as6500_spi_emu dut (
    .i_clk_100m     (clk),
    .i_rst_n        (rst_n),
    .i_tdc_spi_ssn  (ssn),
    .i_tdc_spi_clk  (sck),
    .i_tdc_spi_mosi (mosi),
    .o_tdc_spi_miso (miso),
    .o_tdc_intn     (intn),
    .i_res_load     (res_load),
    .i_res_data     (res_data),
    .o_meas_en      (meas_en),
    .o_cfg_wr       (cfg_wr),
    .o_cfg_addr     (cfg_addr),
    .o_cfg_data     (cfg_data),
    .o_proto_err    (proto_err)
  );

  // Log every configuration write pulse
  always @(negedge clk) begin
    if (cfg_wr) begin
      wr_a.push_back(cfg_addr);
      wr_d.push_back(cfg_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input int idx, input logic [4:0] ea, input logic [7:0] ed);
    logic [4:0] ga;
    logic [7:0] gd;
    ga = 5'h1F;
    gd = 8'hEE;
    if (wr_a.size() > idx) begin
      ga = wr_a[idx];
      gd = wr_d[idx];
    end
    chk($sformatf("wr%0d_addr", idx), ga, ea);
    chk($sformatf("wr%0d_data", idx), gd, ed);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      sck  = 1'b1;
      mosi = tx[i];
      #50;
      rx[i] = miso;
      sck   = 1'b0;
      #50;
    end
  endtask

  task automatic frame_start();
    ssn = 1'b0;
    #60;
  endtask

  task automatic frame_end();
    ssn = 1'b1;
    #120;
  endtask

  task automatic load_res(input logic [7:0] b0, input logic [7:0] b1);
    @(negedge clk);
    res_data       = '0;
    res_data[7:0]  = b0;
    res_data[15:8] = b1;
    res_load       = 1'b1;
    @(negedge clk);
    res_load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    logic [7:0] op;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_miso", miso, 1'b0);
    chk("rst_intn", intn, 1'b1);
    chk("rst_meas_en", meas_en, 1'b0);
    chk("rst_cfg_wr", cfg_wr, 1'b0);
    chk("rst_cfg_addr", cfg_addr, 5'd0);
    chk("rst_cfg_data", cfg_data, 8'h00);
    chk("rst_proto_err", proto_err, 1'b0);

    // 1: Init, then write two registers and read them back
    frame_start(); xfer(8'h18, rx); frame_end();
    chk("init_meas_en", meas_en, 1'b1);
    wr_a.delete(); wr_d.delete();
    frame_start(); xfer(8'h83, rx); xfer(8'hA5, rx); xfer(8'h5A, rx); frame_end();
    chk("wr1_count", wr_a.size(), 2);
    chk_wr(0, 5'd3, 8'hA5);
    chk_wr(1, 5'd4, 8'h5A);
    frame_start(); xfer(8'h43, rx);
    chk("opcode_miso", rx, 8'h00);
    xfer(8'h00, rx); chk("rdcfg3", rx, 8'hA5);
    xfer(8'h00, rx); chk("rdcfg4", rx, 8'h5A);
    frame_end();

    // 2: write wraps from the last register to 0
    wr_a.delete(); wr_d.delete();
    frame_start(); xfer(8'h90, rx); xfer(8'h11, rx); xfer(8'h22, rx); frame_end();
    chk("wr2_count", wr_a.size(), 2);
    chk_wr(0, 5'd16, 8'h11);
    chk_wr(1, 5'd0, 8'h22);
    frame_start(); xfer(8'h50, rx);
    xfer(8'h00, rx); chk("rdcfg16", rx, 8'h11);
    xfer(8'h00, rx); chk("rdcfg0_wrap", rx, 8'h22);
    frame_end();

    // 3: load results, read them, interrupt released 4 cycles after SSN rises
    load_res(8'hC3, 8'h3C);
    chk("load_intn", intn, 1'b0);
    frame_start(); xfer(8'h68, rx);
    xfer(8'h00, rx); chk("rdres8", rx, 8'hC3);
    xfer(8'h00, rx); chk("rdres9", rx, 8'h3C);
    chk("intn_in_frame", intn, 1'b0);
    ssn = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("intn_ssn_rise_3", intn, 1'b0);
    @(posedge clk);
    #1 chk("intn_ssn_rise_4", intn, 1'b1);
    @(negedge clk);
    #100;
    frame_start(); xfer(8'h62, rx);
    xfer(8'h00, rx); chk("rdres_clamp", rx, 8'hC3);
    frame_end();

    // 4: load during an active read is deferred to the end of the frame
    frame_start(); xfer(8'h68, rx);
    xfer(8'h00, rx); chk("rdres_pre", rx, 8'hC3);
    load_res(8'h77, 8'h00);
    chk("intn_pending", intn, 1'b1);
    xfer(8'h00, rx); chk("rdres_old", rx, 8'h3C);
    frame_end();
    chk("intn_after_pend", intn, 1'b0);
    frame_start(); xfer(8'h68, rx);
    xfer(8'h00, rx); chk("rdres_new", rx, 8'h77);
    frame_end();
    chk("intn_after_read", intn, 1'b1);

    // 5: abort mid-byte, then power-on reset
    load_res(8'h99, 8'h00);
    chk("intn_load2", intn, 1'b0);
    chk("err_before_abort", proto_err, 1'b0);
    wr_a.delete(); wr_d.delete();
    op = 8'h80;
    frame_start();
    for (int i = 7; i >= 3; i--) begin
      sck  = 1'b1;
      mosi = op[i];
      #50;
      sck = 1'b0;
      #50;
    end
    frame_end();
    chk("abort_no_wr", wr_a.size(), 0);
    chk("abort_intn", intn, 1'b0);
    chk("abort_err", proto_err, EXP_ABORT_ERR);

    frame_start(); xfer(8'h30, rx); frame_end();
    chk("por_meas_en", meas_en, 1'b0);
    chk("por_err", proto_err, 1'b0);
    chk("por_intn", intn, 1'b1);
    frame_start(); xfer(8'h40, rx);
    for (int i = 0; i < 17; i++) begin
      xfer(8'h00, rx);
      chk($sformatf("por_cfg%0d", i), rx, 8'h00);
    end
    frame_end();
    load_res(8'h55, 8'h55);
    chk("load_dropped", intn, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
